hack_cpu_mem: RTL and testbench

- Parametrised successor of the Hack CPU. Same ISA semantics (A-/C-instructions, ALU, dest and jump fields), generalised data/address width.
- Adds ready-based instruction fetch and variable-latency data-memory handshakes with a small stall FSM, so it can sit in front of slow RAM/ROM models instead of only ideal single-cycle memories.

---
 rtl/hack_pkg.sv | 26 ++
 rtl/hack_alu.sv | 31 +++
 rtl/hack_cpu_mem.sv | 144 ++++++++++++++
 tb/tb_hack_cpu_mem.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU family: instruction bit positions,
// stall-FSM state encoding and the jump-condition helper.
package hack_pkg;

  localparam int A_BIT  = 12;
  localparam int ZX     = 11;
  localparam int NX     = 10;
  localparam int ZY     = 9;
  localparam int NY     = 8;
  localparam int F      = 7;
  localparam int NO     = 6;
  localparam int DEST_A = 5;
  localparam int DEST_D = 4;
  localparam int DEST_M = 3;
  localparam int J1     = 2;
  localparam int J2     = 1;
  localparam int J3     = 0;

  typedef enum logic [1:0] {EXEC, WAIT_RD, WAIT_WR} cpu_state_t;

  // j = {j1, j2, j3}: jump on negative, zero, strictly positive.
  function automatic logic jumpTaken(input logic [2:0] j, input logic zr, input logic ng);
    return (j[2] && ng) || (j[1] && zr) || (j[0] && !zr && !ng);
  endfunction

endpackage

// File: rtl/hack_alu.sv
// Standard Hack ALU, DATA_W wide, purely combinational (modulo 2^DATA_W).
module hack_alu #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] y,
  input  logic                     zx,
  input  logic                     nx,
  input  logic                     zy,
  input  logic                     ny,
  input  logic                     f,
  input  logic                     no,
  output logic signed [DATA_W-1:0] out,
  output logic                     zr,
  output logic                     ng
);

  logic signed [DATA_W-1:0] xz, xn, yz, yn, fOut;

  always_comb begin
    xz   = zx ? '0 : x;
    xn   = nx ? ~xz : xz;
    yz   = zy ? '0 : y;
    yn   = ny ? ~yz : yz;
    fOut = f ? (xn + yn) : (xn & yn);
    out  = no ? ~fOut : fOut;
    zr   = (out == '0);
    ng   = (out < 0);
  end

endmodule

// File: rtl/hack_cpu_mem.sv
// Hack CPU with ready-based fetch and variable-latency data memory.
// Optional halt-on-self-jump detection is built when HACK_CPU_HALT_EN is defined.
module hack_cpu_mem
  import hack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instruction,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] inM,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] outM,
  output logic [ADDR_W-1:0] addressM,
  output logic              writeM,
  output logic              readM,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  cpu_state_t               state, nextState;
  logic signed [DATA_W-1:0] aReg, dReg, mQ, yOp, aluOut;
  logic [ADDR_W-1:0]        pcReg;
  logic                     zr, ng, commit, latchM, haltQ;
  logic                     isC, needRd, needWr, jump;
  logic [2:0]               jBits;

  assign isC    = instruction[DATA_W-1];
  assign needRd = isC && instruction[A_BIT];
  assign needWr = isC && instruction[DEST_M];
  assign jBits  = {instruction[J1], instruction[J2], instruction[J3]};
  assign jump   = isC && jumpTaken(jBits, zr, ng);

  // Once the read has landed in mQ, the write phase must not depend on inM.
  assign yOp = !instruction[A_BIT] ? aReg :
               (state == WAIT_WR)  ? mQ   : $signed(inM);

  hack_alu #(.DATA_W(DATA_W)) uAlu (
    .x  (dReg),
    .y  (yOp),
    .zx (instruction[ZX]),
    .nx (instruction[NX]),
    .zy (instruction[ZY]),
    .ny (instruction[NY]),
    .f  (instruction[F]),
    .no (instruction[NO]),
    .out(aluOut),
    .zr (zr),
    .ng (ng)
  );

  always_comb begin
    nextState = state;
    commit    = 1'b0;
    latchM    = 1'b0;
    readM     = 1'b0;
    writeM    = 1'b0;
    if (!haltQ) begin
      case (state)
        EXEC: begin
          if (instr_valid) begin
            if (needRd) begin
              readM = 1'b1;
              if (!mem_ready)  nextState = WAIT_RD;
              else if (needWr) begin
                latchM    = 1'b1;
                nextState = WAIT_WR;
              end else         commit = 1'b1;
            end else if (needWr) begin
              writeM = 1'b1;
              if (mem_ready) commit = 1'b1;
              else           nextState = WAIT_WR;
            end else begin
              commit = 1'b1;
            end
          end
        end
        WAIT_RD: begin
          readM = 1'b1;
          if (mem_ready) begin
            if (needWr) begin
              latchM    = 1'b1;
              nextState = WAIT_WR;
            end else begin
              commit    = 1'b1;
              nextState = EXEC;
            end
          end
        end
        WAIT_WR: begin
          writeM = 1'b1;
          if (mem_ready) begin
            commit    = 1'b1;
            nextState = EXEC;
          end
        end
        default: nextState = EXEC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EXEC;
      aReg  <= '0;
      dReg  <= '0;
      mQ    <= '0;
      pcReg <= '0;
    end else begin
      state <= nextState;
      if (latchM) mQ <= $signed(inM);
      if (commit) begin
        if (!isC) begin
          aReg <= {1'b0, instruction[DATA_W-2:0]};
        end else begin
          if (instruction[DEST_A]) aReg <= aluOut;
          if (instruction[DEST_D]) dReg <= aluOut;
        end
        pcReg <= jump ? aReg[ADDR_W-1:0] : pcReg + ADDR_W'(1);
      end
    end
  end

`ifdef HACK_CPU_HALT_EN
  always_ff @(posedge clk) begin
    if (reset)
      haltQ <= 1'b0;
    else if (commit && isC && (jBits == 3'b111) && (aReg[ADDR_W-1:0] == pcReg))
      haltQ <= 1'b1;
  end
`else
  assign haltQ = 1'b0;
`endif

  assign halted      = haltQ;
  assign instr_ready = commit;
  assign outM        = aluOut;
  assign addressM    = aReg[ADDR_W-1:0];
  assign pc          = pcReg;

endmodule

// File: tb/tb_hack_cpu_mem.sv
// Self-checking bench for hack_cpu_mem: directed scenarios plus randomized
// instruction streams scored against an ISA-level reference model.
module tb_hack_cpu_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;

  localparam logic [5:0] C_ZERO = 6'b101010;
  localparam logic [5:0] C_M1   = 6'b111010;
  localparam logic [5:0] C_D    = 6'b001100;
  localparam logic [5:0] C_Y    = 6'b110000;
  localparam logic [5:0] C_YP1  = 6'b110111;
  localparam logic [5:0] C_DPY  = 6'b000010;

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] inM;
  logic              mem_ready;
  logic [DATA_W-1:0] outM;
  logic [ADDR_W-1:0] addressM;
  logic              writeM;
  logic              readM;
  logic [ADDR_W-1:0] pc;
  logic              halted;

  hack_cpu_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .inM        (inM),
    .mem_ready  (mem_ready),
    .outM       (outM),
    .addressM   (addressM),
    .writeM     (writeM),
    .readM      (readM),
    .pc         (pc),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;

  // Reference architectural state and data memory.
  logic [15:0] mA, mD;
  logic [14:0] mPc;
  logic [15:0] mem [0:32767];
  logic [5:0]  comps [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000,
                              6'b001101, 6'b110001, 6'b001111, 6'b110011, 6'b011111,
                              6'b110111, 6'b001110, 6'b110010, 6'b000010, 6'b010011,
                              6'b000111, 6'b000000, 6'b010101};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hack comp mnemonics by their arithmetic meaning; y is A or M.
  function automatic logic [15:0] aluRef(input logic [5:0] c, input logic [15:0] d, input logic [15:0] y);
    case (c)
      6'b101010: return 16'd0;
      6'b111111: return 16'd1;
      6'b111010: return 16'hFFFF;
      6'b001100: return d;
      6'b110000: return y;
      6'b001101: return ~d;
      6'b110001: return ~y;
      6'b001111: return -d;
      6'b110011: return -y;
      6'b011111: return d + 16'd1;
      6'b110111: return y + 16'd1;
      6'b001110: return d - 16'd1;
      6'b110010: return y - 16'd1;
      6'b000010: return d + y;
      6'b010011: return d - y;
      6'b000111: return y - d;
      6'b000000: return d & y;
      6'b010101: return d | y;
      default:   return 16'd0;
    endcase
  endfunction

  function automatic logic jumpRef(input logic [2:0] j, input logic [15:0] r);
    logic signed [15:0] s;
    s = r;
    return (j[2] && s < 0) || (j[1] && s == 0) || (j[0] && s > 0);
  endfunction

  function automatic logic [15:0] cIns(input logic a, input logic [5:0] c, input logic [2:0] d, input logic [2:0] j);
    return {3'b111, a, c, d, j};
  endfunction

  // Present one instruction until it retires; rdWait/wrWait are not-ready cycles per phase.
  task automatic runInstr(input logic [15:0] ins, input int rdWait, input int wrWait);
    logic        isC, needRd, needWr, inRd, inWr, rdy, commitExp;
    logic [15:0] mVal, yv, res, nA, nD;
    logic [14:0] nPc, oldAddr;
    int          cnt;
    isC     = ins[15];
    needRd  = isC && ins[12];
    needWr  = isC && ins[3];
    oldAddr = mA[14:0];
    mVal    = mem[oldAddr];
    yv      = ins[12] ? mVal : mA;
    res     = aluRef(ins[11:6], mD, yv);
    nA      = mA;
    nD      = mD;
    nPc     = mPc + 15'd1;
    if (!isC) nA = {1'b0, ins[14:0]};
    else begin
      if (ins[5]) nA = res;
      if (ins[4]) nD = res;
      if (jumpRef(ins[2:0], res)) nPc = oldAddr;
    end
    inRd = needRd;
    inWr = needWr && !needRd;
    cnt  = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      instruction = ins;
      instr_valid = 1'b1;
      if (inRd)      rdy = (cnt == rdWait);
      else if (inWr) rdy = (cnt == wrWait);
      else           rdy = 1'($urandom_range(0, 1));
      mem_ready = rdy;
      inM       = (inRd && rdy) ? mVal : 16'($urandom);
      commitExp = (inRd && rdy && !needWr) || (inWr && rdy) || (!inRd && !inWr);
      #1;
      check("instr_ready", 32'(instr_ready), 32'(commitExp));
      check("readM", 32'(readM), 32'(inRd));
      check("writeM", 32'(writeM), 32'(inWr));
      check("pc", 32'(pc), 32'(mPc));
      check("addressM", 32'(addressM), 32'(oldAddr));
      if (inWr) check("outM", 32'(outM), 32'(res));
      if (commitExp) break;
      if (inRd && rdy) begin
        inRd = 1'b0;
        inWr = 1'b1;
        cnt  = 0;
      end else begin
        cnt++;
      end
    end
    if (needWr) mem[oldAddr] = res;
    mA  = nA;
    mD  = nD;
    mPc = nPc;
  endtask

  task automatic idleCycle();
    @(negedge clk);
    instr_valid = 1'b0;
    instruction = 16'($urandom);
    mem_ready   = 1'($urandom_range(0, 1));
    inM         = 16'($urandom);
    #1;
    check("idle_ready", 32'(instr_ready), 0);
    check("idle_readM", 32'(readM), 0);
    check("idle_writeM", 32'(writeM), 0);
    check("idle_pc", 32'(pc), 32'(mPc));
  endtask

  task automatic doReset();
    @(negedge clk);
    reset       = 1'b1;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    mA  = 16'd0;
    mD  = 16'd0;
    mPc = 15'd0;
    check("rst_pc", 32'(pc), 0);
    check("rst_addressM", 32'(addressM), 0);
    check("rst_readM", 32'(readM), 0);
    check("rst_writeM", 32'(writeM), 0);
    check("rst_instr_ready", 32'(instr_ready), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_D", 32'(dut.dReg), 0);
  endtask

  initial begin
    logic [15:0] ins, yv;
    logic [5:0]  comp;
    logic        aBit;
    logic [2:0]  jb, dest;
    reset       = 1'b1;
    instruction = '0;
    instr_valid = 1'b0;
    inM         = '0;
    mem_ready   = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    doReset();

    // Zero-wait program computing 15+20 and storing it to address 0.
    runInstr(16'd15, 0, 0);
    runInstr(cIns(1'b0, C_Y, 3'b010, 3'b000), 0, 0);
    runInstr(16'd20, 0, 0);
    runInstr(cIns(1'b0, C_DPY, 3'b010, 3'b000), 0, 0);
    runInstr(16'd0, 0, 0);
    runInstr(cIns(1'b0, C_D, 3'b001, 3'b000), 0, 0);
    check("t1_mem0", 32'(mem[0]), 35);
    idleCycle();

    // Write stalled three cycles.
    runInstr(16'd3, 0, 0);
    runInstr(cIns(1'b0, C_Y, 3'b010, 3'b000), 0, 0);
    runInstr(16'd7, 0, 0);
    runInstr(cIns(1'b0, C_D, 3'b001, 3'b000), 0, 3);

    // Read-modify-write with read latency.
    runInstr(16'd4, 0, 0);
    mem[4] = 16'd41;
    runInstr(cIns(1'b1, C_YP1, 3'b001, 3'b000), 2, 0);
    check("t3_mem4", 32'(mem[4]), 42);

    // Jumps and pc wraparound.
    runInstr(16'd100, 0, 0);
    runInstr(cIns(1'b0, C_M1, 3'b010, 3'b000), 0, 0);
    runInstr(cIns(1'b0, C_D, 3'b000, 3'b100), 0, 0);
    check("t4_jlt_model", 32'(mPc), 100);
    runInstr(cIns(1'b0, C_ZERO, 3'b010, 3'b000), 0, 0);
    runInstr(cIns(1'b0, C_D, 3'b000, 3'b001), 0, 0);
    runInstr(16'd32767, 0, 0);
    runInstr(cIns(1'b0, C_ZERO, 3'b000, 3'b111), 0, 0);
    runInstr(cIns(1'b0, C_ZERO, 3'b010, 3'b000), 0, 0);
    idleCycle();
    check("t4_wrap_pc", 32'(pc), 0);

    // Reset while a read is outstanding; the late read data must not land in D.
    runInstr(16'd9, 0, 0);
    runInstr(cIns(1'b0, C_Y, 3'b010, 3'b000), 0, 0);
    runInstr(16'd4, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      instruction = cIns(1'b1, C_Y, 3'b010, 3'b000);
      instr_valid = 1'b1;
      mem_ready   = 1'b0;
      #1;
      check("t5_readM", 32'(readM), 1);
      check("t5_stall_pc", 32'(pc), 32'(mPc));
    end
    @(negedge clk);
    reset     = 1'b1;
    mem_ready = 1'b1;
    inM       = 16'd123;
    @(negedge clk);
    reset       = 1'b0;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    #1;
    check("t5_pc", 32'(pc), 0);
    check("t5_readM_after", 32'(readM), 0);
    check("t5_A", 32'(dut.aReg), 0);
    check("t5_D", 32'(dut.dReg), 0);
    mA  = 16'd0;
    mD  = 16'd0;
    mPc = 15'd0;

    // Self-jump at pc 3.
    runInstr(16'd0, 0, 0);
    runInstr(16'd0, 0, 0);
    runInstr(16'd3, 0, 0);
`ifdef HACK_CPU_HALT_EN
    runInstr(cIns(1'b0, C_ZERO, 3'b000, 3'b111), 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      instruction = cIns(1'b1, C_YP1, 3'b001, 3'b000);
      instr_valid = 1'b1;
      mem_ready   = 1'b1;
      #1;
      check("t6_halted", 32'(halted), 1);
      check("t6_ready", 32'(instr_ready), 0);
      check("t6_readM", 32'(readM), 0);
      check("t6_writeM", 32'(writeM), 0);
      check("t6_pc", 32'(pc), 3);
    end
`else
    runInstr(cIns(1'b0, C_ZERO, 3'b000, 3'b111), 0, 0);
    runInstr(cIns(1'b0, C_ZERO, 3'b000, 3'b111), 0, 0);
    idleCycle();
    check("t6_pc", 32'(pc), 3);
    check("t6_halted", 32'(halted), 0);
`endif
    doReset();

    // Randomized instruction stream with random memory latencies.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) idleCycle();
      if ($urandom_range(0, 3) == 0) begin
        ins = {1'b0, 15'($urandom)};
      end else begin
        comp = comps[$urandom_range(0, 17)];
        aBit = 1'($urandom);
        dest = 3'($urandom);
        jb   = 3'($urandom);
        ins  = {1'b1, 2'($urandom), aBit, comp, dest, jb};
        yv   = aBit ? mem[mA[14:0]] : mA;
        if (jumpRef(jb, aluRef(comp, mD, yv)) && (mA[14:0] == mPc)) ins[2:0] = 3'b000;
      end
      runInstr(ins, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    idleCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
